qpro_status_gen: RTL and testbench

Parametrised multi-channel status-output generator; successor to the single `status` output of the top-level template design. It drives `CHANNELS` status lines, each independently programmed to off, on, blink or a repeating bit pattern. All channels advance on a shared prescaled tick. Configuration arrives over a valid/ready write port from the surrounding control logic.

---
 rtl/qpro_status_gen.sv | 170 +++++++++++++++++
 tb/tb_qpro_status_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/qpro_status_gen.sv
// ---------------------------------------------------------------------------
// qpro_status_gen
//
// Multi-channel status-output generator. Each of CHANNELS status lines is
// independently programmed to OFF, ON, BLINK or a repeating PAT_WIDTH-bit
// pattern (LSB first). All channels advance together on a shared tick that
// pulses once every PRESCALE clk cycles. Configuration is written through a
// valid/ready port that accepts at most one write every two cycles.
//
// Optional feature macro: QPRO_STATUS_SYNC_EN
//   defined   : every accepted write (valid channel or not) restarts the
//               prescaler, so a freshly written value lasts a full PRESCALE
//               cycles before its first advance.
//   undefined : the prescaler runs freely and writes never disturb it.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   cfg_valid    in   config write request
//   cfg_ready    out  block can accept a write (low for one cycle after each)
//   cfg_chan     in   target channel
//   cfg_mode     in   0 OFF, 1 ON, 2 BLINK, 3 PATTERN
//   cfg_pattern  in   pattern bits, LSB first (PATTERN mode only)
//   cfg_err      out  one-cycle pulse after a write to a nonexistent channel
//   tick         out  one-cycle pulse every PRESCALE cycles
//   status       out  registered status lines, bit i = channel i
// ---------------------------------------------------------------------------
module qpro_status_gen #(
    parameter int CHANNELS  = 4,
    parameter int PRESCALE  = 1000,
    parameter int PAT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [$clog2(CHANNELS)-1:0] cfg_chan,
    input  logic [1:0]                  cfg_mode,
    input  logic [PAT_WIDTH-1:0]        cfg_pattern,
    output logic                        cfg_err,
    output logic                        tick,
    output logic [CHANNELS-1:0]         status
);

    localparam int CHW = $clog2(CHANNELS);
    localparam int CW  = $clog2(PRESCALE);
    localparam int IW  = $clog2(PAT_WIDTH);

    localparam logic [CW-1:0]  CNT_LAST_C = CW'(PRESCALE - 1);
    localparam logic [IW-1:0]  IDX_LAST_C = IW'(PAT_WIDTH - 1);
    // One bit wider than cfg_chan so the limit itself is representable.
    localparam logic [CHW:0]   CHAN_LIM_C = (CHW + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_PATTERN = 2'd3
    } mode_e;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          tick_r;
    logic          ready_r;
    logic          err_r;
    logic          accept_s;
    logic          bad_chan_s;

    // Handshake decode and prescaler next-count.
    always_comb begin
        accept_s   = cfg_valid && ready_r;
        bad_chan_s = ({1'b0, cfg_chan} >= CHAN_LIM_C);
`ifdef QPRO_STATUS_SYNC_EN
        if (accept_s) begin
            cnt_next_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST_C) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + 1'b1;
        end
`else
        if (cnt_r == CNT_LAST_C) begin
            cnt_next_s = {CW{1'b0}};
        end else begin
            cnt_next_s = cnt_r + 1'b1;
        end
`endif
    end

    // Prescaler, tick, and write-port handshake registers. tick is
    // registered from the next count so it is high exactly while
    // cnt == PRESCALE-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            tick_r  <= 1'b0;
            ready_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            tick_r  <= (cnt_next_s == CNT_LAST_C);
            ready_r <= !accept_s;
            err_r   <= accept_s && bad_chan_s;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        localparam logic [CHW:0] CH_ID_C = (CHW + 1)'(g);

        mode_e                mode_r;
        logic [PAT_WIDTH-1:0] pat_r;
        logic [IW-1:0]        idx_r;
        logic                 lvl_r;
        logic                 hit_s;
        logic [IW-1:0]        idx_adv_s;

        // Channel select and wrapped pattern-phase increment.
        always_comb begin
            hit_s = accept_s && ({1'b0, cfg_chan} == CH_ID_C);
            if (idx_r == IDX_LAST_C) begin
                idx_adv_s = {IW{1'b0}};
            end else begin
                idx_adv_s = idx_r + 1'b1;
            end
        end

        // Channel state: a write to this channel takes priority over a
        // coincident tick, so the freshly loaded initial value is held
        // for that edge. The line level doubles as the blink level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_r <= MODE_OFF;
                pat_r  <= {PAT_WIDTH{1'b0}};
                idx_r  <= {IW{1'b0}};
                lvl_r  <= 1'b0;
            end else if (hit_s) begin
                mode_r <= mode_e'(cfg_mode);
                pat_r  <= cfg_pattern;
                idx_r  <= {IW{1'b0}};
                case (mode_e'(cfg_mode))
                    MODE_OFF:     lvl_r <= 1'b0;
                    MODE_ON:      lvl_r <= 1'b1;
                    MODE_BLINK:   lvl_r <= 1'b1;
                    MODE_PATTERN: lvl_r <= cfg_pattern[0];
                    default:      lvl_r <= 1'b0;
                endcase
            end else if (tick_r) begin
                case (mode_r)
                    MODE_OFF:     lvl_r <= 1'b0;
                    MODE_ON:      lvl_r <= 1'b1;
                    MODE_BLINK:   lvl_r <= ~lvl_r;
                    MODE_PATTERN: begin
                        idx_r <= idx_adv_s;
                        lvl_r <= pat_r[idx_adv_s];
                    end
                    default:      lvl_r <= 1'b0;
                endcase
            end else begin
                lvl_r <= lvl_r;
            end
        end

        assign status[g] = lvl_r;
    end

    assign cfg_ready = ready_r;
    assign cfg_err   = err_r;
    assign tick      = tick_r;

endmodule

// File: tb/tb_qpro_status_gen.sv
// ---------------------------------------------------------------------------
// tb_qpro_status_gen
//
// Randomized self-checking bench for qpro_status_gen with CHANNELS=4,
// PRESCALE=4, PAT_WIDTH=8. The reference model tracks, per channel, the
// programmed mode/pattern and how many ticks have elapsed since the last
// write; the expected line level follows directly from that count. Tick
// timing is modelled as an edge count since reset (or since the last
// accepted write when QPRO_STATUS_SYNC_EN is defined).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qpro_status_gen;

    localparam int CH = 4;
    localparam int PS = 4;
    localparam int PW = 8;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       cfg_valid   = 1'b0;
    logic [1:0] cfg_chan    = 2'd0;
    logic [1:0] cfg_mode    = 2'd0;
    logic [7:0] cfg_pattern = 8'd0;
    logic       cfg_ready;
    logic       cfg_err;
    logic       tick;
    logic [3:0] status;

    qpro_status_gen #(
        .CHANNELS  (CH),
        .PRESCALE  (PS),
        .PAT_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_chan    (cfg_chan),
        .cfg_mode    (cfg_mode),
        .cfg_pattern (cfg_pattern),
        .cfg_err     (cfg_err),
        .tick        (tick),
        .status      (status)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int       m_phase;
    bit       m_ready;
    bit       m_err;
    int       m_mode [CH];
    bit [7:0] m_pat  [CH];
    int       m_adv  [CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ready = 1'b1;
        m_err   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0;
            m_pat[c]  = 8'd0;
            m_adv[c]  = 0;
        end
    endtask

    function automatic logic [3:0] exp_status();
        logic [3:0] s;
        s = 4'b0000;
        for (int c = 0; c < CH; c++) begin
            case (m_mode[c])
                1:       s[c] = 1'b1;
                2:       s[c] = ((m_adv[c] % 2) == 0);
                3:       s[c] = m_pat[c][m_adv[c] % PW];
                default: s[c] = 1'b0;
            endcase
        end
        return s;
    endfunction

    function automatic bit exp_tick();
        return ((m_phase % PS) == (PS - 1));
    endfunction

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge(output bit acc);
        bit tk;
        acc = cfg_valid && m_ready;
        tk  = exp_tick();
        for (int c = 0; c < CH; c++) begin
            if (acc && (int'(cfg_chan) == c)) begin
                m_mode[c] = int'(cfg_mode);
                m_pat[c]  = cfg_pattern;
                m_adv[c]  = 0;
            end else if (tk) begin
                m_adv[c]++;
            end
        end
        m_err   = acc && (int'(cfg_chan) >= CH);
        m_ready = !acc;
`ifdef QPRO_STATUS_SYNC_EN
        if (acc) m_phase = 0;
        else     m_phase++;
`else
        m_phase++;
`endif
    endtask

    task automatic compare();
        chk("status", status, exp_status());
        chk("tick", tick, exp_tick());
        chk("cfg_ready", cfg_ready, m_ready);
        chk("cfg_err", cfg_err, m_err);
    endtask

    // Choose next inputs. Segment kind: seg<0 idle, seg%3==2 hammer
    // cfg_valid with new values every cycle, otherwise a well-behaved
    // requester that holds until accepted, at a busy or sparse rate.
    task automatic drive(input bit last_acc, input int seg);
        int rate;
        rate = ((seg % 2) != 0) ? 20 : 3;
        if (seg < 0) begin
            cfg_valid = 1'b0;
        end else if ((seg % 3) == 2) begin
            cfg_valid   = 1'b1;
            cfg_chan    = 2'($urandom_range(0, 3));
            cfg_mode    = 2'($urandom_range(0, 3));
            cfg_pattern = 8'($urandom());
        end else if (cfg_valid && !last_acc) begin
            cfg_valid = 1'b1;
        end else begin
            cfg_valid   = ($urandom_range(0, rate - 1) == 0);
            cfg_chan    = 2'($urandom_range(0, 3));
            cfg_mode    = 2'($urandom_range(0, 3));
            cfg_pattern = 8'($urandom());
        end
    endtask

    task automatic step(input int seg);
        bit acc;
        @(posedge clk);
        model_edge(acc);
        #1;
        drive(acc, seg);
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset in the middle of activity, checked before any edge.
    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("rst_status", status, 32'd0);
        chk("rst_ready", cfg_ready, 32'd1);
        chk("rst_tick", tick, 32'd0);
        chk("rst_err", cfg_err, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        // Quiet period after release: status stays 0, ticks on cycles 3, 7, 11.
        for (int k = 0; k < 14; k++) step(-1);
        for (int seg = 0; seg < 12; seg++) begin
            for (int k = 0; k < 200; k++) step(seg);
            if (seg == 4 || seg == 9) do_reset();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
